dsram_like_slave: RTL and testbench
===================================

DSRAM_LIKE_SLAVE -- requirements
Module: dsram_like_slave

Interface
REQ-001 Parameter ADDR_W, default 12, memory depth 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 1, cycles from head-of-queue to response; legal range 1..15.
REQ-003 Parameter DEPTH, fixed 2, outstanding-request queue entries.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_sram_req  input  1  master request valid.
REQ-007 data_sram_wr  input  1  1 = write, 0 = read.
REQ-008 data_sram_size  input  2  0 = byte, 1 = half, 2 = word; 3 treated as word.
REQ-009 data_sram_addr  input  32  byte address.
REQ-010 data_sram_wdata  input  32  write data, lanes already replicated by master.
REQ-011 data_sram_addr_ok  output  1  request accepted this cycle when high with req.
REQ-012 data_sram_data_ok  output  1  one-cycle response strobe for the head request.
REQ-013 data_sram_rdata  output  32  read data, valid when data_ok is high.

Function
REQ-014 Accept = req && addr_ok; on accept, push {wr, size, addr, wdata} into FIFO tail at the edge.
REQ-015 addr_ok = !reset && (count < DEPTH); no same-cycle pop bypass, so a full queue stalls even if data_ok is high.
REQ-016 Accepted requests are visible at queue head no earlier than the cycle after accept.
REQ-017 head_cnt clears to 0 whenever a new entry becomes head (push into empty queue, or pop with count > 1).
REQ-018 head_cnt increments by 1 each cycle while the head is valid and data_ok is low; saturates at LATENCY-1.
REQ-019 data_ok = head_valid && (head_cnt == LATENCY-1); asserted exactly one cycle per request; pops the head at that edge.
REQ-020 LATENCY=1: accept in cycle T gives data_ok in T+1; back-to-back accepts give one data_ok per cycle.
REQ-021 Responses are strictly in acceptance order; no reordering between reads and writes.
REQ-022 Memory access happens in the data_ok cycle: reads return mem[addr[ADDR_W+1:2]] combinationally; writes commit at that edge.
REQ-023 Write strobes: byte -> 4'b0001 << addr[1:0]; half -> addr[1] ? 4'b1100 : 4'b0011; word/size 3 -> 4'b1111; addr[0] is ignored for half, addr[1:0] for word.
REQ-024 Write responses drive rdata = 32'b0; rdata = 32'b0 whenever data_ok is low.
REQ-025 Read queued behind a write to the same word returns the newly written bytes.
REQ-026 Simultaneous push and pop keeps count unchanged; tail and head pointers wrap modulo DEPTH.
REQ-027 Address bits above ADDR_W+1 are ignored (aliasing).

Reset
REQ-028 During reset: addr_ok = 0, data_ok = 0, rdata = 0; queue count, pointers and head_cnt clear to 0.
REQ-029 Reset mid-operation discards all outstanding requests with no response; uncommitted writes are lost.
REQ-030 Memory contents are not cleared by reset.
REQ-031 First accept is possible in the first cycle with reset low.

Verification
REQ-032 LATENCY=1: write word 0xDEADBEEF at 0x10, then read 0x10 next cycle -> data_ok in two consecutive cycles, second rdata = 0xDEADBEEF.
REQ-033 Byte write 0xAA to 0x13 over word 0x11223344 -> later word read of 0x10 = 0xAA223344; half write 0x5555 to 0x12 -> 0x55553344.
REQ-034 LATENCY=3: three back-to-back reqs -> addr_ok drops on the third until first data_ok+1; data_ok at T+3, T+6, T+9.
REQ-035 Queue full (2 outstanding), req held high -> no accept while count = 2 even in the data_ok cycle; accept the cycle after.
REQ-036 Reset asserted with 2 outstanding requests -> no data_ok ever for them, addr_ok = 0 during reset, count = 0 after.
REQ-037 size = 3 write of 0x01020304 at 0x21 -> full word at 0x20 = 0x01020304.

Source files
------------

// File: rtl/dsram_like_slave_if.sv
// Request/response bus of the data-SRAM-like slave: handshake, payload and response.
interface dsram_like_slave_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/dsram_like_slave.sv
// SRAM-like slave: small in-order request queue, fixed head latency, byte-strobed word memory.
module dsram_like_slave #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DEPTH   = 2
) (
    input logic clk,
    input logic reset,
    dsram_like_slave_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = 4;
    localparam int unsigned WORDS = 1 << ADDR_W;
    localparam logic [LAT_W-1:0] LAST = LAT_W'(LATENCY - 1);

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [1:0]        lo;
        logic [ADDR_W-1:0] widx;
        logic [31:0]       wdata;
    } entry_t;

    logic [31:0]       mem [WORDS];
    entry_t            q   [DEPTH];
    entry_t            in_entry;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [LAT_W-1:0]  head_cnt;
    logic              head_valid;
    logic              addr_ok;
    logic              data_ok;
    logic              push;
    logic              pop;
    logic [3:0]        strb;
    logic              unused_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Only the word index and the byte offset are kept; upper address bits alias.
    always_comb begin
        in_entry       = '0;
        in_entry.wr    = bus.data_sram_wr;
        in_entry.size  = bus.data_sram_size;
        in_entry.lo    = bus.data_sram_addr[1:0];
        in_entry.widx  = bus.data_sram_addr[ADDR_W+1:2];
        in_entry.wdata = bus.data_sram_wdata;
    end

    assign unused_addr = ^bus.data_sram_addr[31:ADDR_W+2];

    assign head       = q[rd_ptr];
    assign head_valid = (count != '0);

    // Full queue stalls even while the head is retiring; no pop bypass.
    always_comb begin
        addr_ok = !reset && (count < CNT_W'(DEPTH));
        data_ok = !reset && head_valid && (head_cnt == LAST);
        push    = bus.data_sram_req && addr_ok;
        pop     = data_ok;
    end

    always_comb begin
        strb = 4'b1111;
        case (head.size)
            2'd0:    strb = 4'b0001 << head.lo;
            2'd1:    strb = head.lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    always_comb begin
        bus.data_sram_addr_ok = addr_ok;
        bus.data_sram_data_ok = data_ok;
        bus.data_sram_rdata   = (data_ok && !head.wr) ? mem[head.widx] : '0;
    end

    // Queue control: pointers, occupancy and head latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop || (push && !head_valid)) begin
                head_cnt <= '0;
            end else if (head_valid && (head_cnt != LAST)) begin
                head_cnt <= head_cnt + LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= in_entry;
    end

    // Writes commit on the edge that retires them; memory survives reset.
    always_ff @(posedge clk) begin
        if (pop && head.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[head.widx][8*b +: 8] <= head.wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dsram_like_slave.sv
// Directed bench: one LATENCY=1 and one LATENCY=3 slave driven cycle by cycle.
module tb_dsram_like_slave;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   errors;
    int   checks;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_3 = 2'd3;

    dsram_like_slave_if a_if ();
    dsram_like_slave_if b_if ();

    dsram_like_slave #(.ADDR_W(12), .LATENCY(1), .DEPTH(2)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if)
    );

    dsram_like_slave #(.ADDR_W(12), .LATENCY(3), .DEPTH(2)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    // Called at posedge+1: drive one cycle, check combinational outputs, advance.
    task automatic cyc(input bit which, input string tag,
                       input logic req, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic e_aok, input logic e_dok, input logic [31:0] e_rd);
        if (which == 1'b0) begin
            a_if.data_sram_req = req; a_if.data_sram_wr = wr; a_if.data_sram_size = size;
            a_if.data_sram_addr = addr; a_if.data_sram_wdata = wdata;
        end else begin
            b_if.data_sram_req = req; b_if.data_sram_wr = wr; b_if.data_sram_size = size;
            b_if.data_sram_addr = addr; b_if.data_sram_wdata = wdata;
        end
        #1;
        if (which == 1'b0) begin
            chk(tag, "addr_ok", {31'b0, a_if.data_sram_addr_ok}, {31'b0, e_aok});
            chk(tag, "data_ok", {31'b0, a_if.data_sram_data_ok}, {31'b0, e_dok});
            chk(tag, "rdata",   a_if.data_sram_rdata, e_rd);
        end else begin
            chk(tag, "addr_ok", {31'b0, b_if.data_sram_addr_ok}, {31'b0, e_aok});
            chk(tag, "data_ok", {31'b0, b_if.data_sram_data_ok}, {31'b0, e_dok});
            chk(tag, "rdata",   b_if.data_sram_rdata, e_rd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        // Requests held high during reset must not be accepted.
        a_if.data_sram_req = 1'b1; a_if.data_sram_wr = 1'b1; a_if.data_sram_size = SZ_W;
        a_if.data_sram_addr = 32'h10; a_if.data_sram_wdata = 32'hFFFF_FFFF;
        b_if.data_sram_req = 1'b1; b_if.data_sram_wr = 1'b1; b_if.data_sram_size = SZ_W;
        b_if.data_sram_addr = 32'h40; b_if.data_sram_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_a", "addr_ok", {31'b0, a_if.data_sram_addr_ok}, 32'd0);
        chk("rst_a", "data_ok", {31'b0, a_if.data_sram_data_ok}, 32'd0);
        chk("rst_a", "rdata",   a_if.data_sram_rdata, 32'd0);
        chk("rst_b", "addr_ok", {31'b0, b_if.data_sram_addr_ok}, 32'd0);
        chk("rst_b", "data_ok", {31'b0, b_if.data_sram_data_ok}, 32'd0);
        chk("rst_b", "rdata",   b_if.data_sram_rdata, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        b_if.data_sram_req = 1'b0;

        // LATENCY=1: one response per cycle, memory effects in order.
        cyc(0, "a01", 1, 1, SZ_W, 32'h10,   32'hDEAD_BEEF, 1, 0, 32'h0);
        cyc(0, "a02", 1, 0, SZ_W, 32'h10,   32'h0,         1, 1, 32'h0);
        cyc(0, "a03", 1, 1, SZ_W, 32'h10,   32'h1122_3344, 1, 1, 32'hDEAD_BEEF);
        cyc(0, "a04", 1, 1, SZ_B, 32'h13,   32'hAAAA_AAAA, 1, 1, 32'h0);
        cyc(0, "a05", 1, 0, SZ_W, 32'h10,   32'h0,         1, 1, 32'h0);
        cyc(0, "a06", 1, 1, SZ_H, 32'h12,   32'h5555_5555, 1, 1, 32'hAA22_3344);
        cyc(0, "a07", 1, 0, SZ_W, 32'h10,   32'h0,         1, 1, 32'h0);
        cyc(0, "a08", 1, 1, SZ_3, 32'h21,   32'h0102_0304, 1, 1, 32'h5555_3344);
        cyc(0, "a09", 1, 0, SZ_W, 32'h20,   32'h0,         1, 1, 32'h0);
        cyc(0, "a10", 1, 1, SZ_B, 32'h21,   32'h7E7E_7E7E, 1, 1, 32'h0102_0304);
        cyc(0, "a11", 1, 1, SZ_H, 32'h20,   32'hBEEF_BEEF, 1, 1, 32'h0);
        cyc(0, "a12", 1, 0, SZ_W, 32'h20,   32'h0,         1, 1, 32'h0);
        cyc(0, "a13", 1, 0, SZ_W, 32'h4010, 32'h0,         1, 1, 32'h0102_BEEF);
        cyc(0, "a14", 0, 0, SZ_W, 32'h0,    32'h0,         1, 1, 32'h5555_3344);
        cyc(0, "a15", 0, 0, SZ_W, 32'h0,    32'h0,         1, 0, 32'h0);

        // LATENCY=3: back-to-back requests, full-queue stall, in-order responses.
        cyc(1, "b00", 1, 1, SZ_W, 32'h40, 32'hCAFE_F00D, 1, 0, 32'h0);
        cyc(1, "b01", 1, 0, SZ_W, 32'h40, 32'h0,         1, 0, 32'h0);
        cyc(1, "b02", 1, 1, SZ_W, 32'h44, 32'h1234_5678, 0, 0, 32'h0);
        cyc(1, "b03", 1, 1, SZ_W, 32'h44, 32'h1234_5678, 0, 1, 32'h0);
        cyc(1, "b04", 1, 1, SZ_W, 32'h44, 32'h1234_5678, 1, 0, 32'h0);
        cyc(1, "b05", 0, 0, SZ_W, 32'h0,  32'h0,         0, 0, 32'h0);
        cyc(1, "b06", 0, 0, SZ_W, 32'h0,  32'h0,         0, 1, 32'hCAFE_F00D);
        cyc(1, "b07", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b08", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b09", 0, 0, SZ_W, 32'h0,  32'h0,         1, 1, 32'h0);
        cyc(1, "b10", 1, 0, SZ_W, 32'h44, 32'h0,         1, 0, 32'h0);
        cyc(1, "b11", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b12", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b13", 0, 0, SZ_W, 32'h0,  32'h0,         1, 1, 32'h1234_5678);

        // Two outstanding writes discarded by reset; memory keeps old contents.
        cyc(1, "b14", 1, 1, SZ_W, 32'h40, 32'h0,         1, 0, 32'h0);
        cyc(1, "b15", 1, 1, SZ_W, 32'h44, 32'h0,         1, 0, 32'h0);
        rst_b = 1'b1;
        cyc(1, "b16", 1, 1, SZ_W, 32'h40, 32'h0,         0, 0, 32'h0);
        cyc(1, "b17", 1, 1, SZ_W, 32'h40, 32'h0,         0, 0, 32'h0);
        rst_b = 1'b0;
        cyc(1, "b18", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b19", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b20", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b21", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b22", 1, 0, SZ_W, 32'h40, 32'h0,         1, 0, 32'h0);
        cyc(1, "b23", 1, 0, SZ_W, 32'h44, 32'h0,         1, 0, 32'h0);
        cyc(1, "b24", 0, 0, SZ_W, 32'h0,  32'h0,         0, 0, 32'h0);
        cyc(1, "b25", 0, 0, SZ_W, 32'h0,  32'h0,         0, 1, 32'hCAFE_F00D);
        cyc(1, "b26", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b27", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);
        cyc(1, "b28", 0, 0, SZ_W, 32'h0,  32'h0,         1, 1, 32'h1234_5678);
        cyc(1, "b29", 0, 0, SZ_W, 32'h0,  32'h0,         1, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
